// File: rtl/psdsquare.sv
// Bit-serial shift-and-add squarer: one multiplier bit per clock, exact
// unsigned xin*xin after NBITSIN iterations, loaded into sq by a stop pulse.
module psdsquare #(
    parameter int NBITSIN = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stop,
    input  logic [NBITSIN-1:0]     xin,
    output logic [2*NBITSIN-1:0]   sq,
    output logic                   busy,
    output logic                   done
);

    localparam int W  = 2 * NBITSIN;
    localparam int CW = $clog2(NBITSIN + 1);

    logic [W-1:0]       a;
    logic [W-1:0]       acc;
    logic [NBITSIN-1:0] b;
    logic [CW-1:0]      cnt;

    // sq sees the accumulator value from before this edge's update, so a stop
    // coinciding with a start still captures the previous result.
    // NOTE: non-blocking assignments make every register in this block read the
    // pre-edge values, which is exactly the ordering stop-vs-start relies on.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sq <= '0;
        end else if (stop) begin
            sq <= acc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a    <= '0;
            b    <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            a    <= {{NBITSIN{1'b0}}, xin};
            b    <= xin;
            acc  <= '0;
            cnt  <= CW'(NBITSIN);
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy) begin
            // Fixed latency: no early exit once the remaining multiplier bits are zero.
            if (b[0]) begin
                acc <= acc + a;
            end
            a   <= a << 1;
            b   <= b >> 1;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_psdsquare.sv
// Directed and randomized checks of psdsquare against an arithmetic model
// (full square and partial sums of the low multiplier bits).
module tb_psdsquare;

    localparam int N = 16;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             stop  = 1'b0;
    logic [N-1:0]     xin   = '0;
    logic [2*N-1:0]   sq;
    logic             busy;
    logic             done;

    int vectors     = 0;
    int miscompares = 0;

    psdsquare #(.NBITSIN(N)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .xin   (xin),
        .sq    (sq),
        .busy  (busy),
        .done  (done)
    );

    always #5 clock = ~clock;

    // Value the accumulator holds after k iterations: x times its low k bits.
    function automatic logic [63:0] partial(input logic [N-1:0] x, input int k);
        logic [63:0] xm;
        logic [63:0] mask;
        xm   = 64'(x);
        mask = (k >= 64) ? '1 : ((64'd1 << k) - 64'd1);
        return (xm & mask) * xm;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [N-1:0] x);
        start = 1'b1;
        xin   = x;
        tick();
        start = 1'b0;
        xin   = N'($urandom);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Start x, optionally stop on edge E0+k (k=0: no stop), watch busy/done
    // every cycle until the result is complete, then check the captured sq.
    task automatic run_case(input string tag, input logic [N-1:0] x, input int k);
        int total;
        int iters;
        total = (k > N + 1) ? k : N + 1;
        do_start(x);
        check({tag, " busy@E0"}, 64'(busy), 64'd1);
        check({tag, " done@E0"}, 64'(done), 64'd0);
        for (int m = 1; m <= total; m++) begin
            stop = (m == k);
            tick();
            stop = 1'b0;
            check({tag, " busy"}, 64'(busy), 64'(m < N));
            check({tag, " done"}, 64'(done), 64'(m >= N));
        end
        if (k > 0) begin
            iters = (k - 1 < N) ? k - 1 : N;
            check({tag, " sq"}, 64'(sq), partial(x, iters));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset sq",   64'(sq),   64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        tick();
        check("idle busy", 64'(busy), 64'd0);

        run_case("full", 16'hFFFF, 17);
        check("full value", 64'(sq), 64'hFFFE0001);

        run_case("zero", 16'h0000, 17);
        run_case("one", 16'h0001, 17);
        run_case("x100", 16'h0100, 17);
        check("x100 value", 64'(sq), 64'h00010000);

        run_case("partial", 16'h0003, 2);
        check("partial value", 64'(sq), 64'd3);
        do_stop();
        check("partial final", 64'(sq), 64'd9);

        do_start(16'h1234);
        repeat (4) tick();
        run_case("restart", 16'h00FF, 17);
        check("restart value", 64'(sq), 64'h0000FE01);

        run_case("x10", 16'h0010, 0);
        stop = 1'b1;
        do_start(16'h0007);
        stop = 1'b0;
        check("startstop sq",   64'(sq),   64'h100);
        check("startstop busy", 64'(busy), 64'd1);
        repeat (N) tick();
        check("startstop done", 64'(done), 64'd1);
        do_stop();
        check("startstop final", 64'(sq), 64'd49);

        do_start(16'hABCD);
        repeat (8) tick();
        #3;
        reset = 1'b1;
        #1;
        check("async sq",   64'(sq),   64'd0);
        check("async busy", 64'(busy), 64'd0);
        check("async done", 64'(done), 64'd0);
        start = 1'b1;
        xin   = 16'h00FF;
        tick();
        start = 1'b0;
        reset = 1'b0;
        tick();
        check("start in reset busy", 64'(busy), 64'd0);
        check("start in reset done", 64'(done), 64'd0);
        do_stop();
        check("after reset sq", 64'(sq), 64'd0);
        run_case("two", 16'h0002, 17);
        check("two value", 64'(sq), 64'd4);

        for (int i = 0; i < 12; i++) begin
            run_case("random", N'($urandom), int'($urandom_range(N + 3, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/psdsquare.md
Name: psdsquare

Overview:
- Sequential shift-and-add squarer: computes xin*xin as an unsigned integer, one multiplier bit per clock.
- Inverse companion of the bit-serial square-root block; uses the same start/stop pulse protocol.
- Used to produce test operands for the root datapath and to check them, since sqrt(square(x)) must equal x.

Parameters:
- NBITSIN, 16, operand width in bits; legal range 4..32; result width is 2*NBITSIN.

Ports:
- clock  input  1  master clock, rising edge
- reset  input  1  asynchronous reset, active high
- start  input  1  one-cycle pulse; captures xin and begins a new square
- stop  input  1  one-cycle pulse; loads output register sq from the accumulator
- xin  input  NBITSIN  operand, unsigned integer
- sq  output  2*NBITSIN  registered result, unsigned integer
- busy  output  1  high while iterations are in progress
- done  output  1  high from completion until the next start or reset

Behaviour:
- Reset (asynchronous, active high) clears the internal state and the outputs:
  - Internal: multiplicand A (2*NBITSIN bits), multiplier B (NBITSIN bits), accumulator ACC (2*NBITSIN bits) and counter CNT ($clog2(NBITSIN+1) bits) all go to 0.
  - Outputs: sq=0, busy=0, done=0.
- States are implied by busy/done:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1.
- Start, sampled on edge E0, from any state:
  - A <= xin zero-extended; B <= xin; ACC <= 0; CNT <= NBITSIN.
  - busy <= 1; done <= 0.
- Iteration, on each edge while busy=1 and start=0:
  - If B[0]=1, ACC <= ACC + A. The sum is 2*NBITSIN bits wide and cannot overflow, because the final value is at most (2^N-1)^2.
  - A <= A<<1; B <= B>>1; CNT <= CNT-1.
  - When CNT==1 at the edge, the last iteration runs, busy <= 0 and done <= 1.
- Latency:
  - ACC holds the exact square after edge E0+NBITSIN.
  - done is visible in the cycle following that edge.
  - A stop sampled on any edge at or after E0+NBITSIN+1 loads the full result.
- Stop behaviour:
  - On an edge with stop=1, sq <= ACC, using the ACC value before that edge's update.
  - Stop is independent of state. A stop during RUN loads the partial sum and does not abort the iterations.
  - A stop in IDLE after reset loads 0.
- sq holds its value until the next stop or reset. start never modifies sq.
- Start during RUN or DONE restarts immediately with the new xin. The previous computation is discarded.
- Start and stop on the same edge:
  - sq <= the old ACC.
  - Then the restart applies: ACC <= 0 and the other start loads.
- start is ignored while reset=1.
- Reset asserted mid-operation clears everything. After release the block stays in IDLE until a start.
- Iterations continue regardless of stop. Only start or reset alter the sequence.
- No early termination when B becomes 0: the latency is always exactly NBITSIN cycles.
- xin is sampled only at start; it may change freely afterwards.

Test Plan:
- Full scale: reset, then start with xin=16'hFFFF; stop 17 cycles later → sq=32'hFFFE0001, done=1, busy=0; busy stays high for exactly 16 cycles.
- Zero and one: xin=0 then stop after done → sq=0; then xin=1 → sq=1; then xin=16'h0100 → sq=32'h00010000.
- Partial stop: start xin=3; stop sampled on edge E0+2 (after one iteration) → sq=3; then stop after done → sq=9; busy/done timing is unaffected by the early stop.
- Restart mid-operation: start xin=16'h1234; start again 5 cycles later with xin=16'h00FF → after 16 more cycles done=1; stop → sq=32'h0000FE01; no trace of 0x1234.
- Simultaneous start/stop: complete xin=16'h0010 (ACC=0x100); then pulse start (xin=7) and stop on the same edge → sq=32'h00000100, busy=1; stop after done → sq=49.
- Asynchronous reset mid-run: start xin=16'hABCD; assert reset between clock edges 8 cycles in → sq, busy, done go to 0 without waiting for a clock edge; release, stop → sq=0; new start xin=16'h0002 → sq=4 after completion.
